button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Front-end for the push-button feeding the LED sequencer. Synchronises the raw
//  asynchronous button, debounces it, and classifies each press.
//  Emits single-cycle pulses: press, short release, long hold. The sequencer
//  consumes press_pulse as its start/enable event.
// PARAMETERS
//  DEBOUNCE_CYCLES  2_000_000    stable-input cycles needed to accept a level change (20 ms @100 MHz)
//  LONG_CYCLES      100_000_000  debounced-high cycles that make a press "long" (1 s @100 MHz)
// PORTS
//  clk          in   1  system clock, 100 MHz
//  rst          in   1  reset, asynchronous, active-low
//  btn_raw      in   1  raw button, active-high, asynchronous to clk
//  btn_level    out  1  debounced button level
//  press_pulse  out  1  one-cycle pulse on debounced rising edge
//  short_pulse  out  1  one-cycle pulse on release when hold < LONG_CYCLES
//  long_pulse   out  1  one-cycle pulse when hold reaches LONG_CYCLES
//  busy         out  1  high while the FSM is not IDLE
// BEHAVIOUR
//  Reset (rst=0): sync FFs, stable level, both counters, all outputs <= 0; FSM <= IDLE.
//  Sync: 2-FF synchroniser on btn_raw; sync_q is the second stage.
//  Debounce: db_cnt clears whenever sync_q == stable. Otherwise it increments.
//   When db_cnt == DEBOUNCE_CYCLES-1: stable <= sync_q and db_cnt <= 0.
//   A glitch shorter than DEBOUNCE_CYCLES never changes stable.
//   Latency from btn_raw edge to stable change = 2 + DEBOUNCE_CYCLES cycles.
//  btn_level = stable (registered).
//  FSM states: IDLE, PRESSED, HELD.
//   IDLE    : on stable 0->1, assert press_pulse, clear hold_cnt, go to PRESSED.
//   PRESSED : hold_cnt increments each cycle.
//             If hold_cnt == LONG_CYCLES-1: assert long_pulse, go to HELD.
//             Else on stable 1->0: assert short_pulse, go to IDLE.
//   HELD    : hold_cnt frozen; no pulses. On stable 1->0, go to IDLE silently.
//  Pulses are registered and last exactly one cycle.
//  At most one of press/short/long is asserted in any cycle.
//  Simultaneous release and long threshold in the same cycle: long wins; FSM goes
//   to HELD, then sees stable=0 and returns to IDLE with no short_pulse.
//  hold_cnt width = $clog2(LONG_CYCLES); it never wraps.
//  db_cnt width = $clog2(DEBOUNCE_CYCLES); it never wraps.
//  busy = (state != IDLE).
//  Reset mid-press: everything returns to reset values. If the button is still held
//   at reset release, a fresh debounce interval elapses, then press_pulse fires once.
//  Parameter legality: DEBOUNCE_CYCLES >= 2 and LONG_CYCLES >= 2, checked by
//   elaboration-time $error.
// STRUCTURE
//  Shared package btn_pkg:
//   - state enum/localparams ST_IDLE=2'd0, ST_PRESSED=2'd1, ST_HELD=2'd2
//   - default cycle constants for 100 MHz
//  Sub-module debounce_filter (clk, rst, din_async, dout_stable):
//   - holds the synchroniser and db_cnt
//   - reusable for other board buttons
//  Top level holds the FSM, hold_cnt and the pulse registers.
// TESTING (bench overrides DEBOUNCE_CYCLES=8, LONG_CYCLES=32)
//  1. Reset held, btn_raw=1: all outputs 0.
//     After rst release: btn_level rises at cycle 10, press_pulse one cycle later, once.
//  2. btn_raw high for 5 cycles, then low: btn_level, press/short/long all stay 0.
//  3. Press for 20 cycles, release: press_pulse once, then short_pulse once
//     ~10 cycles after release; long_pulse never.
//  4. Press for 60 cycles: press_pulse, then long_pulse 32 cycles later.
//     On release: no short_pulse; busy drops when btn_level falls.
//  5. Bounce train (1,0,1,0 at 3-cycle spacing), then steady 1: exactly one press_pulse.
//  6. Assert rst mid-HELD: outputs 0 immediately, FSM IDLE.
//     With the button still held after release: single press_pulse after debounce.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front-end: FSM encoding and
// default cycle counts for a 100 MHz clock.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;    // 20 ms
    localparam int DEF_LONG_CYCLES     = 100_000_000;  // 1 s

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus stability counter; dout_stable only follows the
// input after it has held a new level for DEBOUNCE_CYCLES consecutive cycles.
module debounce_filter import btn_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din_async,
    output logic dout_stable
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2) begin : g_chk
        $error("debounce_filter: DEBOUNCE_CYCLES must be >= 2");
    end

    logic           sync_d;
    logic           sync_q;
    logic           stable;
    logic [DBW-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_d <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync_d <= din_async;
            sync_q <= sync_d;
        end
    end

    // Any return to the accepted level restarts the count, so glitches shorter
    // than the window are discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (sync_q == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync_q;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign dout_stable = stable;

endmodule

// File: rtl/button_conditioner.sv
// Debounced push-button classifier: emits one-cycle press, short-release and
// long-hold pulses for the LED sequencer.
module button_conditioner import btn_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic busy
);

    localparam int HW = $clog2(LONG_CYCLES);

    if (LONG_CYCLES < 2) begin : g_chk
        $error("button_conditioner: LONG_CYCLES must be >= 2");
    end

    logic          stable;
    logic          stable_d;
    btn_state_t    state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          press_nxt, short_nxt, long_nxt;

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk         (clk),
        .rst         (rst),
        .din_async   (btn_raw),
        .dout_stable (stable)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            stable_d    <= 1'b0;
            hold_cnt    <= '0;
            press_pulse <= 1'b0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            state       <= state_nxt;
            stable_d    <= stable;
            hold_cnt    <= hold_nxt;
            press_pulse <= press_nxt;
            short_pulse <= short_nxt;
            long_pulse  <= long_nxt;
        end
    end

    // Release is tested as a level so that a release coinciding with the long
    // threshold is still noticed from HELD on the following cycle.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        press_nxt = 1'b0;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stable && !stable_d) begin
                    press_nxt = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (hold_cnt == HW'(LONG_CYCLES - 1)) begin
                    long_nxt  = 1'b1;
                    state_nxt = ST_HELD;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                    if (!stable) begin
                        short_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_HELD: begin
                if (!stable) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign btn_level = stable;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_button_conditioner.sv
// Event-scoreboard bench for button_conditioner with short debounce/long windows.
module tb_button_conditioner;

    localparam int DB = 8;
    localparam int LG = 32;

    localparam int K_LRISE = 0, K_LFALL = 1, K_PRESS = 2, K_SHORT = 3,
                   K_LONG = 4, K_BRISE = 5, K_BFALL = 6;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_level, press_pulse, short_pulse, long_pulse, busy;

    button_conditioner #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .press_pulse (press_pulse),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int kind; } ev_t;
    ev_t sb[$];

    typedef struct {
        string name;
        int    hi;
        bit    exp_press;
        bit    exp_short;
        bit    exp_long;
    } vec_t;
    vec_t tv[7];

    int  n_cmp = 0;
    int  n_bad = 0;
    logic p_lvl = 1'b0;
    logic p_busy = 1'b0;
    int  c;

    // Expected events are kept ordered by (cycle, kind), matching the order
    // in which the monitor reports same-cycle events.
    task automatic expect_ev(input int cy, input int k);
        ev_t e;
        int  i;
        e.cyc = cy; e.kind = k;
        i = 0;
        while (i < sb.size() && (sb[i].cyc < cy || (sb[i].cyc == cy && sb[i].kind < k))) i++;
        sb.insert(i, e);
    endtask

    // Raw input driven high at cycle c for h cycles.
    task automatic push_press(input int c0, input int h, input bit ep, input bit es, input bit el);
        int bf;
        if (ep) begin
            expect_ev(c0 + DB + 2, K_LRISE);
            expect_ev(c0 + DB + 3, K_PRESS);
            expect_ev(c0 + DB + 3, K_BRISE);
            expect_ev(c0 + h + DB + 2, K_LFALL);
        end
        if (es) begin
            expect_ev(c0 + h + DB + 3, K_SHORT);
            expect_ev(c0 + h + DB + 3, K_BFALL);
        end
        if (el) begin
            expect_ev(c0 + DB + 3 + LG, K_LONG);
            bf = c0 + h + DB + 3;
            if (bf < c0 + DB + 4 + LG) bf = c0 + DB + 4 + LG;
            expect_ev(bf, K_BFALL);
        end
    endtask

    task automatic check_ev(input int k);
        n_cmp++;
        if (sb.size() != 0 && sb[0].kind == k && sb[0].cyc == cyc) begin
            void'(sb.pop_front());
        end else begin
            n_bad++;
            if (sb.size() != 0)
                $display("FAIL event: got kind=%0d at cyc=%0d, required kind=%0d at cyc=%0d",
                         k, cyc, sb[0].kind, sb[0].cyc);
            else
                $display("FAIL event: got kind=%0d at cyc=%0d, required none", k, cyc);
        end
    endtask

    // Advance to the next falling edge and compare any output events seen there.
    task automatic tick();
        logic [6:0] ev;
        @(negedge clk);
        if (!rst) begin
            p_lvl  = 1'b0;
            p_busy = 1'b0;
        end else begin
            ev = '0;
            ev[K_LRISE] = btn_level & ~p_lvl;
            ev[K_LFALL] = ~btn_level & p_lvl;
            ev[K_PRESS] = press_pulse;
            ev[K_SHORT] = short_pulse;
            ev[K_LONG]  = long_pulse;
            ev[K_BRISE] = busy & ~p_busy;
            ev[K_BFALL] = ~busy & p_busy;
            for (int k = 0; k < 7; k++) if (ev[k]) check_ev(k);
            p_lvl  = btn_level;
            p_busy = busy;
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic settle(input string name);
        repeat (20) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s missed events: %0d left, first kind=%0d cyc=%0d",
                     name, sb.size(), sb[0].kind, sb[0].cyc);
            sb.delete();
        end
        check_val({name, " idle level/busy"}, {30'd0, btn_level, busy}, 0);
    endtask

    initial begin
        tv[0] = '{"glitch5",  5,  1'b0, 1'b0, 1'b0};
        tv[1] = '{"glitch7",  7,  1'b0, 1'b0, 1'b0};
        tv[2] = '{"min8",     8,  1'b1, 1'b1, 1'b0};
        tv[3] = '{"short20",  20, 1'b1, 1'b1, 1'b0};
        tv[4] = '{"short31",  31, 1'b1, 1'b1, 1'b0};
        tv[5] = '{"tie32",    32, 1'b1, 1'b0, 1'b1};
        tv[6] = '{"long60",   60, 1'b1, 1'b0, 1'b1};

        // Reset held with the button pressed.
        rst = 1'b0;
        btn_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("reset outputs",
                      {27'd0, btn_level, press_pulse, short_pulse, long_pulse, busy}, 0);
        end
        rst = 1'b1;
        c = cyc;
        push_press(c, 15, 1'b1, 1'b1, 1'b0);
        repeat (15) tick();
        btn_raw = 1'b0;
        settle("post-reset press");

        for (int i = 0; i < 7; i++) begin
            tick();
            btn_raw = 1'b1;
            c = cyc;
            push_press(c, tv[i].hi, tv[i].exp_press, tv[i].exp_short, tv[i].exp_long);
            repeat (tv[i].hi) tick();
            btn_raw = 1'b0;
            settle(tv[i].name);
        end

        // Bounce train then steady press.
        tick();
        for (int i = 0; i < 2; i++) begin
            btn_raw = 1'b1;
            repeat (3) tick();
            btn_raw = 1'b0;
            repeat (3) tick();
        end
        btn_raw = 1'b1;
        c = cyc;
        push_press(c, 20, 1'b1, 1'b1, 1'b0);
        repeat (20) tick();
        btn_raw = 1'b0;
        settle("bounce");

        // Reset while in HELD, button still held through reset release.
        tick();
        btn_raw = 1'b1;
        c = cyc;
        expect_ev(c + DB + 2, K_LRISE);
        expect_ev(c + DB + 3, K_PRESS);
        expect_ev(c + DB + 3, K_BRISE);
        expect_ev(c + DB + 3 + LG, K_LONG);
        repeat (50) tick();
        check_val("held busy before reset", {31'd0, busy}, 1);
        rst = 1'b0;
        #1;
        check_val("mid-held reset outputs",
                  {27'd0, btn_level, press_pulse, short_pulse, long_pulse, busy}, 0);
        check_val("events pending at reset", sb.size(), 0);
        sb.delete();
        repeat (3) tick();
        rst = 1'b1;
        c = cyc;
        push_press(c, 15, 1'b1, 1'b1, 1'b0);
        repeat (15) tick();
        btn_raw = 1'b0;
        settle("after mid-held reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
